// File: rtl/serial_add_sub_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_sub_ctrl
//
// Bit-serial WIDTH-bit adder/subtractor. One full-adder cell is stepped over
// the operands LSB first, one bit per clock, so an operation takes
// WIDTH + 2 cycles (IDLE accept, WIDTH RUN cycles, one DONE cycle).
// Subtraction is a + ~b + 1: B is inverted on load and the carry is seeded
// with 1.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   start      operation request, sampled only in IDLE
//   sub        0 = a + b, 1 = a - b, latched with start
//   a_in       operand A, latched with start
//   b_in       operand B, latched with start
//   busy       high while bits are being processed
//   done       one-cycle pulse, result/carry_out/overflow valid
//   result     sum/difference, held until the next operation completes
//   carry_out  carry out of the MSB (subtract: 1 = no borrow)
//   overflow   signed two's-complement overflow
// -----------------------------------------------------------------------------
module serial_add_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_sh;       // operand A, consumed from bit 0
  logic [WIDTH-1:0] b_sh;       // operand B (pre-inverted for subtract)
  logic [WIDTH-1:0] acc_sh;     // partial result, filled from the MSB down
  logic [WIDTH-1:0] acc_nxt;
  logic             carry;      // carry into the bit currently processed
  logic [CW-1:0]    cnt;        // index of the bit currently processed

  logic             sum_bit;
  logic             carry_nxt;
  logic             last_bit;

  // The full-adder cell.
  assign sum_bit   = a_sh[0] ^ b_sh[0] ^ carry;
  assign carry_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  assign last_bit  = (cnt == LAST);

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
  assign acc_nxt   = (acc_sh >> 1) | (WIDTH'(sum_bit) << (WIDTH - 1));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state and handshake outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first so no path through
  // the case leaves one unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand shift registers
  // ---------------------------------------------------------------------------
  // NOTE: the operand registers carry no reset; they are always loaded on an
  // accepted start before the RUN state reads them, so a reset adds nothing.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      a_sh <= a_in;
      b_sh <= sub ? ~b_in : b_in;
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
    end
  end

  // ---------------------------------------------------------------------------
  // Carry, counter, partial result and held outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      carry     <= 1'b0;
      cnt       <= '0;
      acc_sh    <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            carry  <= sub;
            cnt    <= '0;
            acc_sh <= '0;
          end
        end
        RUN: begin
          carry  <= carry_nxt;
          cnt    <= cnt + 1'b1;
          acc_sh <= acc_nxt;
          // Published outputs change only here, so they stay stable
          // through the following DONE and IDLE cycles.
          if (last_bit) begin
            result    <= acc_nxt;
            carry_out <= carry_nxt;
            overflow  <= carry ^ carry_nxt;  // carry into MSB vs out of MSB
          end
        end
        default: ;
      endcase
    end
  end

endmodule
